// File: rtl/pipeline_skid_buffer.sv
// Two-entry ready/valid register slice; all outputs come straight from flops.
// Optional synchronous clear port enabled by PIPELINE_SKID_BUFFER_FLUSH_EN.
module pipeline_skid_buffer #(
  parameter int unsigned               WORD_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  areset,
`ifdef PIPELINE_SKID_BUFFER_FLUSH_EN
  input  logic                  clear,
`endif
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_input_ready;
  logic                  r_output_valid;
  logic [WORD_WIDTH-1:0] r_main;
  logic [WORD_WIDTH-1:0] r_skid;

  logic w_insert;
  logic w_remove;
  logic w_clear;
  logic w_load_main;
  logic w_load_skid;
  logic w_main_from_skid;

  assign w_insert = input_valid & r_input_ready;
  assign w_remove = r_output_valid & output_ready;

`ifdef PIPELINE_SKID_BUFFER_FLUSH_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_insert) begin
          w_state_next = BUSY;
          w_load_main  = 1'b1;
        end
      end
      BUSY: begin
        if (w_insert && !w_remove) begin
          w_state_next = FULL;
          w_load_skid  = 1'b1;
        end else if (!w_insert && w_remove) begin
          w_state_next = EMPTY;
        end else if (w_insert && w_remove) begin
          w_load_main  = 1'b1;
        end
      end
      FULL: begin
        if (w_remove) begin
          w_state_next     = BUSY;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
    // clear wins over any handshake on the same edge
    if (w_clear) begin
      w_state_next     = EMPTY;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_state        <= EMPTY;
      r_output_valid <= 1'b0;
      r_input_ready  <= 1'b1;
    end else begin
      r_state        <= w_state_next;
      r_output_valid <= (w_state_next != EMPTY);
      r_input_ready  <= (w_state_next != FULL);
    end
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_main <= RESET_VALUE;
      r_skid <= RESET_VALUE;
    end else if (w_clear) begin
      r_main <= RESET_VALUE;
      r_skid <= RESET_VALUE;
    end else begin
      if (w_load_main) begin
        r_main <= input_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= input_data;
      end
    end
  end

  assign input_ready  = r_input_ready;
  assign output_valid = r_output_valid;
  assign output_data  = r_main;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Scoreboard bench for pipeline_skid_buffer: a queue models buffer contents.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipeline_skid_buffer;

  logic       clock;
  logic       areset;
  logic       input_valid;
  logic       input_ready;
  logic [7:0] input_data;
  logic       output_valid;
  logic       output_ready;
  logic [7:0] output_data;
`ifdef PIPELINE_SKID_BUFFER_FLUSH_EN
  logic       clear;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  logic [7:0] got[$];

  pipeline_skid_buffer #(
    .WORD_WIDTH (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .clock       (clock),
    .areset      (areset),
`ifdef PIPELINE_SKID_BUFFER_FLUSH_EN
    .clear       (clear),
`endif
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_data  (input_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_data (output_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle: drive, compare against the model, then advance the model.
  task automatic step(input logic iv, input logic [7:0] d,
                      input logic ordy);
    bit ins;
    bit rem;
    input_valid  = iv;
    input_data   = d;
    output_ready = ordy;
    #1;
    n_checks++;
    if (output_valid !== (sb.size() != 0)) begin
      n_fail++;
      $display("FAIL sb_valid: got %b want %b", output_valid,
               sb.size() != 0);
    end
    n_checks++;
    if (input_ready !== (sb.size() < 2)) begin
      n_fail++;
      $display("FAIL sb_ready: got %b want %b", input_ready,
               sb.size() < 2);
    end
    if (sb.size() != 0) begin
      n_checks++;
      if (output_data !== sb[0]) begin
        n_fail++;
        $display("FAIL sb_data: got %h want %h", output_data, sb[0]);
      end
    end
    rem = ordy && (sb.size() != 0);
    ins = iv && (sb.size() < 2);
    if (rem) got.push_back(sb.pop_front());
    if (ins) sb.push_back(d);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1",
               output_valid, input_ready);
    end
    n_checks++;
    if (output_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 00", output_data);
    end
    @(negedge clock);
    areset = 1'b0;
  endtask

  task automatic test_stream();
    got.delete();
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (got.size() != 16) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want 16", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL stream_order[%0d]: got %h want %h",
                 i, got[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_full_stall();
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    #1;
    n_checks++;
    if (input_ready !== 1'b0 || output_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_hs: got r=%b v=%b want r=0 v=1",
               input_ready, output_valid);
    end
    n_checks++;
    if (output_data !== 8'hA1) begin
      n_fail++;
      $display("FAIL full_data: got %h want a1", output_data);
    end
    @(negedge clock);
  endtask

  task automatic test_drain();
    got.delete();
    step(1'b1, 8'hA3, 1'b1);
    step(1'b1, 8'hA3, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL drain_count: got %0d want 3", got.size());
    end else begin
      n_checks++;
      if (got[0] !== 8'hA1 || got[1] !== 8'hA2 || got[2] !== 8'hA3) begin
        n_fail++;
        $display("FAIL drain_order: got %h %h %h want a1 a2 a3",
                 got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] pre;
    logic       iv;
    logic       ordy;
    int         n_in;
    got.delete();
    n_in = 0;
    for (int i = 0; i < 10000; i++) begin
      pre  = {input_ready, output_valid};
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      input_valid  = iv;
      output_ready = ordy;
      input_data   = 8'($urandom);
      #1;
      n_checks++;
      if ({input_ready, output_valid} !== pre) begin
        n_fail++;
        $display("FAIL rand_comb: got %b want %b",
                 {input_ready, output_valid}, pre);
      end
      if (iv && sb.size() < 2) n_in++;
      step(iv, input_data, ordy);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (got.size() != n_in || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d want %0d", got.size(), n_in);
    end
  endtask

  task automatic test_reset_full();
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    input_valid  = 1'b1;
    input_data   = 8'hEE;
    output_ready = 1'b1;
    #2;
    areset = 1'b1;
    #1;
    n_checks++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_hs: got v=%b r=%b want v=0 r=1",
               output_valid, input_ready);
    end
    n_checks++;
    if (output_data !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_data: got %h want 00", output_data);
    end
    sb.delete();
    @(negedge clock);
    areset = 1'b0;
    input_valid = 1'b0;
    #1;
    n_checks++;
    if (output_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_no_xfer: got v=%b want 0", output_valid);
    end
    @(negedge clock);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);
  endtask

`ifdef PIPELINE_SKID_BUFFER_FLUSH_EN
  task automatic test_clear();
    got.delete();
    step(1'b1, 8'hC1, 1'b0);
    input_valid  = 1'b1;
    input_data   = 8'hC3;
    output_ready = 1'b0;
    clear        = 1'b1;
    @(negedge clock);
    clear       = 1'b0;
    input_valid = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_hs: got v=%b r=%b want v=0 r=1",
               output_valid, input_ready);
    end
    @(negedge clock);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (got.size() != 0) begin
      n_fail++;
      $display("FAIL clear_drop: got %0d words want 0", got.size());
    end
  endtask
`endif

  initial begin
    areset       = 1'b1;
    input_valid  = 1'b0;
    input_data   = 8'h00;
    output_ready = 1'b0;
`ifdef PIPELINE_SKID_BUFFER_FLUSH_EN
    clear        = 1'b0;
`endif
    test_reset();
    test_stream();
    test_full_stall();
    test_drain();
    test_random();
    test_reset_full();
`ifdef PIPELINE_SKID_BUFFER_FLUSH_EN
    test_clear();
`endif
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
